// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: turns rising edges on per-neuron spike inputs into
// address events. Pending bits feed a round-robin arbiter that pushes one
// neuron index per cycle into a first-word-fall-through FIFO.
// Optional build macro AER_TIMESTAMP_EN adds a free-running timestamp that
// is captured per neuron on each event and carried with the FIFO entry.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 3,
    parameter int ADDR_W     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [ADDR_W-1:0]    aer_addr,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_W-1:0]      aer_ts,
`endif
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [N_NEURONS-1:0] spike_q;
    logic [N_NEURONS-1:0] pending;
    logic [N_NEURONS-1:0] evt;
    logic [N_NEURONS-1:0] grant_vec;
    logic [N_NEURONS-1:0] drop_vec;
    logic [ADDR_W-1:0]    last_grant;
    logic [ADDR_W-1:0]    grant_idx;
    logic                 grant_ok;
    logic [PW:0]          wr_ptr;
    logic [PW:0]          rd_ptr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic [9:0]           drop_n;
    logic [9:0]           drop_sum;
    logic [ADDR_W-1:0]    addr_mem [FIFO_DEPTH];

    assign evt        = spike_in & ~spike_q;
    assign drop_vec   = evt & pending & ~grant_vec;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign aer_valid  = !fifo_empty;
    assign aer_addr   = fifo_empty ? '0 : addr_mem[rd_ptr[PW-1:0]];
    assign pop        = aer_valid && aer_ready;
    assign drop_sum   = {2'b00, drop_cnt} + drop_n;

    // Round-robin pick: indices above last_grant first, then wrap to 0.
    // A pop in the same cycle does not free a slot for this push.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        if (!fifo_full) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (!grant_ok && pending[i] && (i > int'(last_grant))) begin
                    grant_ok     = 1'b1;
                    grant_idx    = ADDR_W'(i);
                    grant_vec[i] = 1'b1;
                end
            end
            for (int i = 0; i < N_NEURONS; i++) begin
                if (!grant_ok && pending[i] && (i <= int'(last_grant))) begin
                    grant_ok     = 1'b1;
                    grant_idx    = ADDR_W'(i);
                    grant_vec[i] = 1'b1;
                end
            end
        end
    end

    // Number of events dropped this cycle.
    always_comb begin
        drop_n = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            drop_n = drop_n + 10'(drop_vec[i]);
        end
    end

    // Edge detect, pending set/clear, arbiter history, FIFO pointers, drop stats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q    <= '0;
            pending    <= '0;
            last_grant <= ADDR_W'(N_NEURONS - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            spike_q <= spike_in;
            pending <= (pending & ~grant_vec) | evt;
            if (grant_ok) begin
                last_grant <= grant_idx;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            drop_cnt <= (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
            if (|drop_vec) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (grant_ok) begin
            addr_mem[wr_ptr[PW-1:0]] <= grant_idx;
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_cap [N_NEURONS];
    logic [TS_W-1:0] grant_ts;
    logic [TS_W-1:0] ts_mem [FIFO_DEPTH];

    assign aer_ts = fifo_empty ? '0 : ts_mem[rd_ptr[PW-1:0]];

    // Timestamp belonging to the neuron being granted.
    always_comb begin
        grant_ts = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (grant_vec[i]) begin
                grant_ts = ts_cap[i];
            end
        end
    end

    // Free-running counter; capture only on accepted events so a dropped
    // event never rewrites the stamp of the one still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                ts_cap[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (evt[i] && !drop_vec[i]) begin
                    ts_cap[i] <= ts_cnt;
                end
            end
        end
    end

    // Timestamp half of the FIFO entry.
    always_ff @(posedge clk) begin
        if (grant_ok) begin
            ts_mem[wr_ptr[PW-1:0]] <= grant_ts;
        end
    end
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: directed scenarios plus a random phase, all
// compared every cycle against a queue-based reference model of the encoder.
module tb_spike_aer_encoder;

    localparam int N     = 3;
    localparam int AW    = 2;
    localparam int DEPTH = 8;
    localparam int TW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  spike_in;
    logic          aer_valid;
    logic          aer_ready;
    logic [AW-1:0] aer_addr;
    logic [TW-1:0] aer_ts;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend;
    int           m_last;
    int           m_cap [N];
    int           m_ts;
    int           m_drop;
    bit           m_ovf;
    int           q_addr [$];
    int           q_ts [$];

    spike_aer_encoder #(
        .N_NEURONS (N),
        .ADDR_W    (AW),
        .FIFO_DEPTH(DEPTH),
        .TS_W      (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spike_in (spike_in),
        .aer_valid(aer_valid),
        .aer_ready(aer_ready),
        .aer_addr (aer_addr),
`ifdef AER_TIMESTAMP_EN
        .aer_ts   (aer_ts),
`endif
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

`ifndef AER_TIMESTAMP_EN
    assign aer_ts = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_pend = '0;
        m_last = N - 1;
        m_ts   = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        for (int i = 0; i < N; i++) m_cap[i] = 0;
        q_addr.delete();
        q_ts.delete();
    endtask

    // One clock edge of the encoder's behaviour, derived from its rules.
    task automatic model_edge(input logic [N-1:0] sp, input logic rd);
        logic [N-1:0] ev;
        logic [N-1:0] pend_old;
        int g;
        int drops;
        ev       = sp & ~m_prev;
        pend_old = m_pend;
        g        = -1;
        if (pend_old != 0 && q_addr.size() < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (g < 0 && pend_old[c]) g = c;
            end
        end
        if (q_addr.size() > 0 && rd) begin
            void'(q_addr.pop_front());
            void'(q_ts.pop_front());
        end
        if (g >= 0) begin
            q_addr.push_back(g);
            q_ts.push_back(m_cap[g]);
            m_last    = g;
            m_pend[g] = 1'b0;
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (pend_old[i] && i != g) drops++;
                else begin
                    m_pend[i] = 1'b1;
                    m_cap[i]  = m_ts;
                end
            end
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        if (drops > 0) m_ovf = 1'b1;
        m_prev = sp;
        m_ts   = (m_ts + 1) % (1 << TW);
    endtask

    task automatic compare_all();
        check("valid", 32'(aer_valid), 32'(q_addr.size() > 0));
        check("addr", 32'(aer_addr), (q_addr.size() > 0) ? 32'(q_addr[0]) : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`ifdef AER_TIMESTAMP_EN
        check("ts", 32'(aer_ts), (q_ts.size() > 0) ? 32'(q_ts[0]) : 32'd0);
`endif
    endtask

    task automatic step(input logic [N-1:0] sp, input logic rd);
        spike_in  = sp;
        aer_ready = rd;
        @(posedge clk);
        model_edge(sp, rd);
        #1;
        compare_all();
    endtask

    // Asserts reset between edges so the clear must be asynchronous.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(aer_valid), 32'd0);
        check("rst_addr", 32'(aer_addr), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`ifdef AER_TIMESTAMP_EN
        check("rst_ts", 32'(aer_ts), 32'd0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hits;
        spike_in  = '0;
        aer_ready = 1'b0;
        apply_reset();

        // single pulse on neuron 1
        step(3'b010, 1'b1);
        check("lat_k", 32'(aer_valid), 32'd0);
        step(3'b000, 1'b1);
        check("lat_k1_valid", 32'(aer_valid), 32'd1);
        check("lat_k1_addr", 32'(aer_addr), 32'd1);
        step(3'b000, 1'b1);
        check("lat_k2_valid", 32'(aer_valid), 32'd0);

        // simultaneous burst, then again after reset
        for (int r = 0; r < 2; r++) begin
            apply_reset();
            step(3'b111, 1'b1);
            for (int a = 0; a < 3; a++) begin
                step(3'b000, 1'b1);
                check("burst_valid", 32'(aer_valid), 32'd1);
                check("burst_addr", 32'(aer_addr), 32'(a));
            end
            step(3'b000, 1'b1);
            check("burst_done", 32'(aer_valid), 32'd0);
        end

        // held-high input gives exactly one event
        hits = 0;
        for (int c = 0; c < 24; c++) begin
            step((c < 20) ? 3'b100 : 3'b000, 1'b1);
            if (aer_valid && aer_addr == 2'd2) hits++;
        end
        check("held_events", 32'(hits), 32'd1);

        // FIFO fill with consumer stalled, then overflow
        apply_reset();
        for (int j = 0; j < 10; j++) begin
            step(3'(1 << (j % 3)), 1'b0);
            step(3'b000, 1'b0);
        end
        check("full_head", 32'(aer_addr), 32'd0);
        check("full_ovf_clear", 32'(overflow), 32'd0);
        check("full_drop0", 32'(drop_cnt), 32'd0);
        step(3'b100, 1'b0);
        step(3'b000, 1'b0);
        check("drop1_ovf", 32'(overflow), 32'd1);
        check("drop1_cnt", 32'(drop_cnt), 32'd1);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        check("drop2_cnt", 32'(drop_cnt), 32'd2);
        check("drop2_head", 32'(aer_addr), 32'd0);

        // multi-drop cycles drive the counter into saturation
        for (int c = 0; c < 400; c++) step((c % 2 == 0) ? 3'b111 : 3'b000, 1'b0);
        check("sat_cnt", 32'(drop_cnt), 32'd255);
        for (int c = 0; c < 20; c++) step(3'b000, 1'b1);
        check("drain_empty", 32'(aer_valid), 32'd0);

        // reset with four queued events
        apply_reset();
        step(3'b111, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        check("q4_valid", 32'(aer_valid), 32'd1);
        apply_reset();
        for (int c = 0; c < 6; c++) step(3'b000, 1'b1);
        check("no_stale", 32'(aer_valid), 32'd0);
        check("no_stale_drop", 32'(drop_cnt), 32'd0);

        // inputs high through reset produce events on release
        spike_in = 3'b111;
        apply_reset();
        step(3'b111, 1'b1);
        step(3'b111, 1'b1);
        check("release_evt", 32'(aer_addr), 32'd0);
        for (int c = 0; c < 4; c++) step(3'b000, 1'b1);

        // random traffic
        for (int c = 0; c < 500; c++) begin
            step(3'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 20; c++) step(3'b000, 1'b1);

`ifdef AER_TIMESTAMP_EN
        apply_reset();
        while (m_ts != 100) step(3'b000, 1'b0);
        step(3'b001, 1'b0);
        while (m_ts != 105) step(3'b000, 1'b0);
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        check("ts_first", 32'(aer_ts), 32'd100);
        step(3'b000, 1'b1);
        check("ts_second", 32'(aer_ts), 32'd105);
        step(3'b000, 1'b1);

        apply_reset();
        while (m_ts != 65535) step(3'b000, 1'b1);
        step(3'b001, 1'b0);
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        check("ts_wrap_hi", 32'(aer_ts), 32'd65535);
        step(3'b000, 1'b1);
        check("ts_wrap_lo", 32'(aer_ts), 32'd0);
        step(3'b000, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 Parameter N_NEURONS, default 3: number of spike inputs, one per neuron i_out.
REQ-002 Parameter ADDR_W, default 2: address width; SHALL satisfy 2**ADDR_W >= N_NEURONS.
REQ-003 Parameter FIFO_DEPTH, default 8: event FIFO entries; SHALL be a power of two, >= 2.
REQ-004 Parameter TS_W, default 16: timestamp width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 spike_in  input  N_NEURONS  neuron spike levels; bit i comes from neuron i.
REQ-008 aer_valid  output  1  FIFO head holds a valid event.
REQ-009 aer_ready  input  1  consumer accepts the head event.
REQ-010 aer_addr  output  ADDR_W  neuron index of the head event.
REQ-011 aer_ts  output  TS_W  capture timestamp of the head event; present only with AER_TIMESTAMP_EN.
REQ-012 overflow  output  1  sticky flag: at least one event dropped since reset.
REQ-013 drop_cnt  output  8  number of dropped events, saturating at 255.

Function
REQ-014 Edge detect: register spike_q <= spike_in; event i at an edge where spike_in[i]=1 and spike_q[i]=0; a held-high input yields exactly one event.
REQ-015 pending[i] SHALL set on event i; it clears when i is granted; set wins if both occur in the same cycle.
REQ-016 Event i while pending[i] is already 1 and not granted that cycle: drop; drop_cnt += 1 (saturating); overflow <= 1.
REQ-017 Multiple drops in one cycle: drop_cnt SHALL add the count of dropped bits, saturating at 255.
REQ-018 Arbiter: each cycle with pending != 0 and FIFO not full, grant exactly one index, round-robin starting at last_grant+1 modulo N_NEURONS; push {index, ts} into the FIFO; update last_grant.
REQ-019 FIFO full: no grant; pending bits hold. A pop in the same cycle does not enable a push.
REQ-020 FIFO is first-word-fall-through: aer_valid = not empty; aer_addr and aer_ts show the head entry.
REQ-021 Pop when aer_valid and aer_ready at the clock edge; aer_addr and aer_ts SHALL remain stable while aer_valid=1 and aer_ready=0.
REQ-022 Push and pop in the same cycle (not full) SHALL leave occupancy unchanged.
REQ-023 Latency: event detected at edge k -> grant and push at edge k+1 -> aer_valid=1 after edge k+1 if the FIFO was empty and there was no contention.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-025 rst=1 SHALL asynchronously clear spike_q, pending, last_grant (to N_NEURONS-1, so index 0 is first after reset), FIFO pointers, drop_cnt, overflow and the timestamp counter.
REQ-026 During reset: aer_valid=0, aer_addr=0, aer_ts=0, overflow=0, drop_cnt=0.
REQ-027 Reset mid-operation SHALL discard all pending and queued events without emitting them.
REQ-028 Release: a spike_in bit high on the first edge after reset SHALL produce an event, because spike_q=0.

Configuration
REQ-029 Macro AER_TIMESTAMP_EN defined:
- a TS_W free-running counter increments every cycle and wraps 2**TS_W-1 -> 0;
- per-neuron capture registers latch the counter on event i;
- the captured value is stored with the FIFO entry and driven on aer_ts.
REQ-030 AER_TIMESTAMP_EN undefined: no counter, no capture registers, no aer_ts port; FIFO entries are ADDR_W wide; all other behaviour identical.

Verification
REQ-031 Single pulse on spike_in[1], FIFO empty, aer_ready=1 -> one event addr=1, aer_valid high one cycle, 2 cycles after the edge.
REQ-032 spike_in=3'b111 rising in one cycle, aer_ready=1 -> addrs 0,1,2 on consecutive cycles; a repeat burst after reset yields 0,1,2 again.
REQ-033 aer_ready=0, 10 distinct single-neuron events (FIFO_DEPTH=8) -> 8 queued, head stable; with pending held, overflow=1 only after a further event on a pending bit; each subsequent drop increments drop_cnt by 1.
REQ-034 spike_in[2] held high for 20 cycles -> exactly one event addr=2.
REQ-035 With AER_TIMESTAMP_EN, spike_in[0] at counter 100 and spike_in[1] at counter 105, aer_ready=0 until both are queued -> aer_ts=100 then 105; counter wrap from 65535 to 0 is observed on aer_ts.
REQ-036 rst asserted with 4 queued events -> aer_valid=0 immediately (asynchronous); after release, no stale events appear and drop_cnt=0.
